// File: rtl/meikyuu_room_ctrl_if.sv
// meikyuu_room_ctrl_if: player/VGA-side bus of the room sequencer.
//   master (player/timing side): drives frame_start, player_x, player_y, btn_any.
//   slave  (room controller):    drives room_x, room_y, tile_code, pos_load,
//                                new_x, new_y, freeze, fade_level, game_state.
interface meikyuu_room_ctrl_if;
  logic       frame_start;
  logic [9:0] player_x;
  logic [9:0] player_y;
  logic       btn_any;
  logic [1:0] room_x;
  logic [1:0] room_y;
  logic [3:0] tile_code;
  logic       pos_load;
  logic [9:0] new_x;
  logic [9:0] new_y;
  logic       freeze;
  logic [3:0] fade_level;
  logic [2:0] game_state;
  modport master (
    output frame_start, player_x, player_y, btn_any,
    input  room_x, room_y, tile_code, pos_load, new_x, new_y, freeze, fade_level, game_state
  );
  modport slave (
    input  frame_start, player_x, player_y, btn_any,
    output room_x, room_y, tile_code, pos_load, new_x, new_y, freeze, fade_level, game_state
  );
endinterface

// File: rtl/meikyuu_room_ctrl.sv
// meikyuu_room_ctrl: 3x3 room sequencer and title/play/win game flow.
//   CLOCK_50 : system clock
//   reset    : asynchronous active-high reset
//   bus      : meikyuu_room_ctrl_if.slave (frame/player/button in; room, tile,
//              position load, freeze, fade and game state out)
//   Build option MEIKYUU_ROOM_FADE_EN adds the fade-out/fade-in states.
module meikyuu_room_ctrl #(
  parameter logic [9:0] X_MIN        = 10'd97,
  parameter logic [9:0] X_MAX        = 10'd720,
  parameter logic [9:0] Y_MIN        = 10'd3,
  parameter logic [9:0] Y_MAX        = 10'd466,
  parameter logic [9:0] ENTRY_MARGIN = 10'd8,
  parameter logic [9:0] START_X      = 10'd400,
  parameter logic [9:0] START_Y      = 10'd232,
  parameter logic [1:0] GOAL_RX      = 2'd2,
  parameter logic [1:0] GOAL_RY      = 2'd2,
  parameter logic [6:0] WIN_HOLD     = 7'd120
) (
  input logic CLOCK_50,
  input logic reset,
  meikyuu_room_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    TITLE    = 3'd0,
    PLAY     = 3'd1,
    FADE_OUT = 3'd2,
    SWAP     = 3'd3,
    FADE_IN  = 3'd4,
    WIN      = 3'd5
  } state_t;
  // Room tile codes, nibble index = room_y*3 + room_x.
  localparam logic [35:0] MAP = 36'h213060514;
  state_t     state;
  logic [1:0] rx, ry, dir_n, sd, srx, sry;
  logic [3:0] tile, fade, idx;
  logic [9:0] nx, ny, sx, sy, snx, sny;
  logic [6:0] cnt;
  logic       pos_load, freeze, go_l, go_r, go_u, go_d, exit_any, at_goal;
`ifdef MEIKYUU_ROOM_FADE_EN
  logic [1:0] dir;
  logic [9:0] lx, ly;
`endif
  assign go_l     = bus.player_x <= X_MIN && rx != 2'd0;
  assign go_r     = bus.player_x >= X_MAX && rx != 2'd2;
  assign go_u     = bus.player_y <= Y_MIN && ry != 2'd0;
  assign go_d     = bus.player_y >= Y_MAX && ry != 2'd2;
  assign exit_any = go_l | go_r | go_u | go_d;
  assign dir_n    = go_l ? 2'd0 : go_r ? 2'd1 : go_u ? 2'd2 : 2'd3;
  assign at_goal  = rx == GOAL_RX && ry == GOAL_RY;
  assign idx      = {2'b00, ry} * 4'd3 + {2'b00, rx};
  // With fading the swap happens frames after the exit, so it uses the
  // direction and position latched at exit time.
`ifdef MEIKYUU_ROOM_FADE_EN
  assign sd = dir;
  assign sx = lx;
  assign sy = ly;
`else
  assign sd = dir_n;
  assign sx = bus.player_x;
  assign sy = bus.player_y;
`endif
  assign srx = sd == 2'd0 ? rx - 2'd1 : sd == 2'd1 ? rx + 2'd1 : rx;
  assign sry = sd == 2'd2 ? ry - 2'd1 : sd == 2'd3 ? ry + 2'd1 : ry;
  assign snx = sd == 2'd0 ? X_MAX - ENTRY_MARGIN : sd == 2'd1 ? X_MIN + ENTRY_MARGIN : sx;
  assign sny = sd == 2'd2 ? Y_MAX - ENTRY_MARGIN : sd == 2'd3 ? Y_MIN + ENTRY_MARGIN : sy;
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      state    <= TITLE;
      rx       <= 2'd0;
      ry       <= 2'd0;
      tile     <= 4'd4;
      pos_load <= 1'b0;
      nx       <= START_X;
      ny       <= START_Y;
      freeze   <= 1'b1;
      fade     <= 4'd15;
      cnt      <= 7'd0;
`ifdef MEIKYUU_ROOM_FADE_EN
      dir      <= 2'd0;
      lx       <= 10'd0;
      ly       <= 10'd0;
`endif
    end else begin
      pos_load <= 1'b0;
      tile     <= MAP[{idx, 2'b00} +: 4];
      case (state)
        TITLE:
          if (bus.frame_start && bus.btn_any) begin
            rx       <= 2'd0;
            ry       <= 2'd0;
            nx       <= START_X;
            ny       <= START_Y;
            pos_load <= 1'b1;
            freeze   <= 1'b0;
            state    <= PLAY;
          end
        PLAY:
          if (bus.frame_start && exit_any) begin
            freeze <= 1'b1;
`ifdef MEIKYUU_ROOM_FADE_EN
            dir    <= dir_n;
            lx     <= bus.player_x;
            ly     <= bus.player_y;
            state  <= FADE_OUT;
`else
            rx       <= srx;
            ry       <= sry;
            nx       <= snx;
            ny       <= sny;
            pos_load <= 1'b1;
            state    <= SWAP;
`endif
          end
`ifdef MEIKYUU_ROOM_FADE_EN
        FADE_OUT:
          if (bus.frame_start) begin
            fade <= fade == 4'd0 ? 4'd0 : fade - 4'd1;
            if (fade <= 4'd1) begin
              rx       <= srx;
              ry       <= sry;
              nx       <= snx;
              ny       <= sny;
              pos_load <= 1'b1;
              state    <= SWAP;
            end
          end
        SWAP: state <= FADE_IN;
        FADE_IN:
          if (bus.frame_start) begin
            fade <= fade == 4'd15 ? 4'd15 : fade + 4'd1;
            if (fade >= 4'd14) begin
              state  <= at_goal ? WIN : PLAY;
              freeze <= at_goal;
              cnt    <= 7'd0;
            end
          end
`else
        SWAP: begin
          state  <= at_goal ? WIN : PLAY;
          freeze <= at_goal;
          cnt    <= 7'd0;
        end
`endif
        WIN:
          if (bus.frame_start) begin
            cnt <= cnt == 7'h7f ? cnt : cnt + 7'd1;
            if (cnt >= WIN_HOLD && bus.btn_any) begin
              rx    <= 2'd0;
              ry    <= 2'd0;
              state <= TITLE;
            end
          end
        default: state <= TITLE;
      endcase
    end
  assign bus.room_x     = rx;
  assign bus.room_y     = ry;
  assign bus.tile_code  = tile;
  assign bus.pos_load   = pos_load;
  assign bus.new_x      = nx;
  assign bus.new_y      = ny;
  assign bus.freeze     = freeze;
  assign bus.fade_level = fade;
  assign bus.game_state = state;
endmodule

// File: tb/tb_meikyuu_room_ctrl.sv
// tb_meikyuu_room_ctrl: directed checks of the room sequencer (either build).
module tb_meikyuu_room_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  meikyuu_room_ctrl_if bus();
  meikyuu_room_ctrl dut (.CLOCK_50(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic frame(input logic b);
    bus.btn_any = b;
    @(negedge clk) bus.frame_start = 1'b1;
    @(negedge clk) bus.frame_start = 1'b0;
  endtask
  task automatic frames(input int n);
    repeat (n) frame(1'b0);
  endtask
  task automatic move(input int x, input int y);
    bus.player_x = 10'(x);
    bus.player_y = 10'(y);
    frame(1'b0);
    for (int i = 0; i < 40 && !(bus.game_state == 3'd1 || bus.game_state == 3'd5); i++)
      if (bus.game_state == 3'd3) @(negedge clk);
      else frame(1'b0);
    if (!(bus.game_state == 3'd1 || bus.game_state == 3'd5))
      chk("move_timeout", bus.game_state, 1);
  endtask
  initial begin
    bus.frame_start = 1'b0;
    bus.btn_any = 1'b0;
    bus.player_x = 10'd400;
    bus.player_y = 10'd232;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_state", bus.game_state, 0);
    chk("rst_room_x", bus.room_x, 0);
    chk("rst_room_y", bus.room_y, 0);
    chk("rst_tile", bus.tile_code, 4);
    chk("rst_fade", bus.fade_level, 15);
    chk("rst_freeze", bus.freeze, 1);
    chk("rst_pos_load", bus.pos_load, 0);
    chk("rst_new_x", bus.new_x, 400);
    chk("rst_new_y", bus.new_y, 232);
    frame(1'b0);
    chk("title_idle", bus.game_state, 0);
    frame(1'b1);
    bus.btn_any = 1'b0;
    chk("start_load", bus.pos_load, 1);
    chk("start_new_x", bus.new_x, 400);
    chk("start_new_y", bus.new_y, 232);
    chk("start_state", bus.game_state, 1);
    chk("start_freeze", bus.freeze, 0);
    @(negedge clk);
    chk("start_load_once", bus.pos_load, 0);
    bus.player_x = 10'd97;
    bus.player_y = 10'd3;
    frame(1'b0);
    chk("border_state", bus.game_state, 1);
    chk("border_room_x", bus.room_x, 0);
    chk("border_room_y", bus.room_y, 0);
`ifdef MEIKYUU_ROOM_FADE_EN
    bus.player_x = 10'd720;
    bus.player_y = 10'd300;
    frame(1'b0);
    chk("fo_state", bus.game_state, 2);
    chk("fo_fade0", bus.fade_level, 15);
    chk("fo_freeze", bus.freeze, 1);
    frames(7);
    chk("fo_fade7", bus.fade_level, 8);
    frames(7);
    chk("fo_fade14", bus.fade_level, 1);
    chk("fo_state14", bus.game_state, 2);
    frame(1'b0);
    chk("swap_state", bus.game_state, 3);
    chk("swap_room_x", bus.room_x, 1);
    chk("swap_new_x", bus.new_x, 105);
    chk("swap_new_y", bus.new_y, 300);
    chk("swap_load", bus.pos_load, 1);
    chk("swap_fade", bus.fade_level, 0);
    @(negedge clk);
    chk("fi_tile", bus.tile_code, 1);
    chk("fi_state", bus.game_state, 4);
    chk("fi_load_off", bus.pos_load, 0);
    frames(14);
    chk("fi_state14", bus.game_state, 4);
    chk("fi_fade14", bus.fade_level, 14);
    frame(1'b0);
    chk("fi_play", bus.game_state, 1);
    chk("fi_fade15", bus.fade_level, 15);
    chk("fi_freeze", bus.freeze, 0);
    move(200, 466);
`else
    bus.player_x = 10'd200;
    bus.player_y = 10'd466;
    frame(1'b0);
    chk("swap_state", bus.game_state, 3);
    chk("swap_room_x", bus.room_x, 0);
    chk("swap_room_y", bus.room_y, 1);
    chk("swap_new_x", bus.new_x, 200);
    chk("swap_new_y", bus.new_y, 11);
    chk("swap_load", bus.pos_load, 1);
    chk("swap_fade", bus.fade_level, 15);
    @(negedge clk);
    chk("after_state", bus.game_state, 1);
    chk("after_tile", bus.tile_code, 0);
    chk("after_load", bus.pos_load, 0);
    chk("after_freeze", bus.freeze, 0);
    move(720, 200);
`endif
    chk("at11_room_x", bus.room_x, 1);
    chk("at11_room_y", bus.room_y, 1);
    chk("at11_tile", bus.tile_code, 6);
    move(97, 3);
    chk("corner_room_x", bus.room_x, 0);
    chk("corner_room_y", bus.room_y, 1);
    chk("corner_new_x", bus.new_x, 712);
    chk("corner_new_y", bus.new_y, 3);
    move(720, 466);
    chk("rd_room_x", bus.room_x, 1);
    chk("rd_room_y", bus.room_y, 1);
    chk("rd_new_x", bus.new_x, 105);
    chk("rd_new_y", bus.new_y, 466);
    move(720, 232);
    chk("at21_room_x", bus.room_x, 2);
    chk("at21_tile", bus.tile_code, 0);
    move(400, 466);
    chk("goal_state", bus.game_state, 5);
    chk("goal_room_y", bus.room_y, 2);
    chk("goal_tile", bus.tile_code, 2);
    chk("goal_new_y", bus.new_y, 11);
    chk("goal_freeze", bus.freeze, 1);
    frames(118);
    frame(1'b1);
    chk("win_btn119", bus.game_state, 5);
    frame(1'b1);
    chk("win_btn120", bus.game_state, 5);
    frame(1'b1);
    chk("win_exit", bus.game_state, 0);
    chk("win_room_x", bus.room_x, 0);
    chk("win_room_y", bus.room_y, 0);
    frame(1'b1);
    bus.btn_any = 1'b0;
    chk("restart_state", bus.game_state, 1);
`ifdef MEIKYUU_ROOM_FADE_EN
    bus.player_x = 10'd720;
    bus.player_y = 10'd232;
    frames(9);
    chk("pre_rst_fade", bus.fade_level, 7);
`else
    move(720, 232);
    chk("pre_rst_room_x", bus.room_x, 1);
`endif
    #2 reset = 1'b1;
    #1;
    chk("arst_state", bus.game_state, 0);
    chk("arst_room_x", bus.room_x, 0);
    chk("arst_room_y", bus.room_y, 0);
    chk("arst_fade", bus.fade_level, 15);
    chk("arst_freeze", bus.freeze, 1);
    chk("arst_tile", bus.tile_code, 4);
    chk("arst_load", bus.pos_load, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_load", bus.pos_load, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/meikyuu_room_ctrl.md
# meikyuu_room_ctrl

Game-flow and room sequencer for the meikyuu maze. Tracks which of the 3×3 rooms the player occupies and selects that room's tile code for the wall/collision datapath. On frame boundaries it detects screen-edge exits, fades out, swaps rooms, reloads the player position and fades back in. It also runs the title → play → win game states, sitting between the VGA timing counters, the player block and the map renderer.

## Interface
- `X_MIN`, default 97: leftmost player x (screen-counter coords).
- `X_MAX`, default 720: rightmost player x (736 − 16).
- `Y_MIN`, default 3: topmost player y.
- `Y_MAX`, default 466: bottommost player y (482 − 16).
- `ENTRY_MARGIN`, default 8: inset from the opposite edge after a room swap.
- `START_X` / `START_Y`, default 400 / 232: spawn position.
- `GOAL_RX` / `GOAL_RY`, default 2 / 2: goal room.
- `WIN_HOLD`, default 120: frames spent in WIN before a button is accepted.

Ports (name, direction, width, meaning):
- `CLOCK_50`  in  1  system clock.
- `reset`  in  1  reset, asynchronous, active-high; clock CLOCK_50.
- `frame_start`  in  1  one-cycle pulse per frame (start of vertical blank).
- `player_x`, `player_y`  in  10  current player top-left.
- `btn_any`  in  1  OR of the debounced buttons.
- `room_x`, `room_y`  out  2  current room, 0..2.
- `tile_code`  out  4  map code of the current room.
- `pos_load`  out  1  one-cycle strobe: player must load `new_x` / `new_y`.
- `new_x`, `new_y`  out  10  position to load.
- `freeze`  out  1  player movement inhibited.
- `fade_level`  out  4  renderer brightness (15 = full, 0 = black).
- `game_state`  out  3  TITLE=0, PLAY=1, FADE_OUT=2, SWAP=3, FADE_IN=4, WIN=5.

## Operation
- Fixed map, row = `room_y`: row0 {4,1,5}, row1 {0,6,0}, row2 {3,1,2}.
- `tile_code` is registered from the map and follows a room change by one cycle.

**TITLE**
- `freeze` = 1.
- On `frame_start` with `btn_any` = 1: room := (0,0), `new_x` / `new_y` := `START_X` / `START_Y`, `pos_load` pulses, go to PLAY.

**PLAY**
- `freeze` = 0.
- Exit checks are evaluated only on `frame_start`:
  - left: `player_x` ≤ `X_MIN` and `room_x` > 0
  - right: `player_x` ≥ `X_MAX` and `room_x` < 2
  - up: `player_y` ≤ `Y_MIN` and `room_y` > 0
  - down: `player_y` ≥ `Y_MAX` and `room_y` < 2
- Priority: left > right > up > down. Horizontal wins at corners.
- An exit at the map border is ignored; the player stays in PLAY.
- On an accepted exit, latch the direction and go to FADE_OUT (fade configuration) or SWAP (no fade).

**FADE_OUT**
- `freeze` = 1.
- `fade_level` decrements once per `frame_start`.
- The edge on which it becomes 0 enters SWAP.

**SWAP** (exactly one cycle)
- Room registers and `new_x` / `new_y` are updated on the entering edge.
- `pos_load` = 1 during this cycle. Entry positions:
  - left exit: x = `X_MAX` − `ENTRY_MARGIN`
  - right exit: x = `X_MIN` + `ENTRY_MARGIN`
  - up exit: y = `Y_MAX` − `ENTRY_MARGIN`
  - down exit: y = `Y_MIN` + `ENTRY_MARGIN`
  - the other axis keeps the player's latched value.
- Next state is FADE_IN, or PLAY when fade is not compiled in.

**FADE_IN**
- `fade_level` increments once per `frame_start`.
- On reaching 15, go to WIN if room == (`GOAL_RX`, `GOAL_RY`), otherwise PLAY.

**WIN**
- `freeze` = 1.
- A frame counter counts to `WIN_HOLD`.
- After that, `frame_start` with `btn_any` = 1 returns to TITLE with room (0,0).

**Arithmetic**
- `fade_level` saturates: no wrap below 0 or above 15.
- Frame counter is 7-bit and saturating.

## Timing
- Reset values:
  - state TITLE, room (0,0), `tile_code` 4
  - `fade_level` 15, `freeze` 1, `pos_load` 0
  - `new_x` / `new_y` = `START_X` / `START_Y`, frame counter 0
- All outputs are registered. State changes occur on the CLOCK_50 edge that samples `frame_start` = 1, except SWAP → next, which is unconditional after one cycle.
- Exit to restored brightness takes 15 + 15 frames with fade; exactly one `frame_start` edge plus one cycle without fade.
- `pos_load` is high for exactly one cycle per load. The player block samples `new_x` / `new_y` on that cycle.
- Inputs other than `frame_start` are ignored between pulses.
- Reset mid-operation returns all state to reset values immediately; no `pos_load` is emitted.

## Configuration
- `MEIKYUU_ROOM_FADE_EN` defined: FADE_OUT and FADE_IN are present as described above.
- Undefined: PLAY → SWAP → PLAY directly. `fade_level` is tied to 15; states 2 and 4 are never reached.

## Test plan
- Reset asserted mid-FADE_OUT (`fade_level` = 7) → immediately state 0, room (0,0), `fade_level` 15, `freeze` 1, `tile_code` 4.
- TITLE, `btn_any` = 1 on `frame_start` → `pos_load` one cycle, `new_x` = 400, `new_y` = 232, state PLAY.
- Room (0,0), `player_x` = 720 on `frame_start` (fade build) → 15 frames to `fade_level` 0, SWAP with room (1,0), `new_x` = 105, `new_y` unchanged; `tile_code` = 1 the next cycle; PLAY after 15 more frames.
- Room (1,1), `player_x` = 97, `player_y` = 3 → left exit chosen, room (0,1). Room (0,0), `player_x` = 97 → no transition.
- Reach room (2,2) → WIN after FADE_IN. `btn_any` before 120 frames is ignored; after 120 frames → TITLE.
- Build without `MEIKYUU_ROOM_FADE_EN`, down exit from (0,0) → SWAP one cycle after `frame_start`, room (0,1), `new_y` = 11, `fade_level` stays 15.
